// File: rtl/eespfal_pkg.sv
// Shared types and constants for the EESPFAL phase driver.
package eespfal_pkg;

  localparam int unsigned BIT_SIZE_DEF     = 4;
  localparam int unsigned PHASE_CYCLES_DEF = 4;
  localparam int unsigned DIS_CYCLES_DEF   = 2;
  localparam int unsigned ERR_CNT_W        = 8;
  localparam int unsigned CNT_W            = 8;

  typedef enum logic [2:0] {
    IDLE,
    DISCHARGE,
    LOAD,
    EVAL,
    HOLD,
    RECOVER,
    WAIT
  } phase_e;

  // Successor of each timed adiabatic phase; WAIT wraps back to IDLE.
  function automatic phase_e next_phase(input phase_e p);
    case (p)
      DISCHARGE: next_phase = LOAD;
      LOAD:      next_phase = EVAL;
      EVAL:      next_phase = HOLD;
      HOLD:      next_phase = RECOVER;
      RECOVER:   next_phase = WAIT;
      default:   next_phase = IDLE;
    endcase
  endfunction

endpackage

// File: rtl/eespfal_rail_checker.sv
// Captures the dual-rail macro result, flags non-complementary rails on
// enabled lanes and keeps a saturating count of faulty captures.
module eespfal_rail_checker
  import eespfal_pkg::*;
#(
  parameter int unsigned BIT_SIZE = BIT_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 capture,
  input  logic [BIT_SIZE-1:0]  mask,
  input  logic [BIT_SIZE-1:0]  s_top,
  input  logic [BIT_SIZE-1:0]  s_bar_top,
  output logic [BIT_SIZE-1:0]  s_out,
  output logic                 s_valid,
  output logic                 s_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  logic rail_fault_c;

  // A lane is faulty when both rails agree (null or short).
  always_comb begin
    rail_fault_c = |(~(s_top ^ s_bar_top) & mask);
  end

  // Result, strobe and saturating fault counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_out   <= '0;
      s_valid <= 1'b0;
      s_err   <= 1'b0;
      err_cnt <= '0;
    end else begin
      s_valid <= capture;
      if (capture) begin
        s_out <= s_top & mask;
        s_err <= rail_fault_c;
        if (rail_fault_c && (err_cnt != {ERR_CNT_W{1'b1}})) begin
          err_cnt <= err_cnt + ERR_CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/eespfal_phase_driver.sv
// Phase sequencer and dual-rail driver for the 4-lane EESPFAL switch macro.
module eespfal_phase_driver
  import eespfal_pkg::*;
#(
  parameter int unsigned BIT_SIZE     = BIT_SIZE_DEF,
  parameter int unsigned PHASE_CYCLES = PHASE_CYCLES_DEF,
  parameter int unsigned DIS_CYCLES   = DIS_CYCLES_DEF
) (
  input  logic                 wb_clk_i,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [BIT_SIZE-1:0]  lane_en,
  input  logic [BIT_SIZE-1:0]  x_in,
  input  logic [BIT_SIZE-1:0]  k_in,
  output logic                 ready,
  output logic                 busy,
  output logic [BIT_SIZE-1:0]  clk_top,
  output logic [BIT_SIZE-1:0]  Dis_top,
  output logic                 Dis_Phase_top,
  output logic [BIT_SIZE-1:0]  x_top,
  output logic [BIT_SIZE-1:0]  x_bar_top,
  output logic [BIT_SIZE-1:0]  k_top,
  output logic [BIT_SIZE-1:0]  k_bar_top,
  input  logic [BIT_SIZE-1:0]  s_top,
  input  logic [BIT_SIZE-1:0]  s_bar_top,
  output logic [BIT_SIZE-1:0]  s_out,
  output logic                 s_valid,
  output logic                 s_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  phase_e              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [BIT_SIZE-1:0] mask, mask_nxt, x, x_nxt, k, k_nxt;
  logic                capture_c;
  logic                ready_nxt, dis_ph_nxt;
  logic [BIT_SIZE-1:0] clk_nxt, dis_nxt, x_top_nxt, x_bar_nxt, k_top_nxt, k_bar_nxt;
  logic                drive, eval;

  // Next phase, operand latch and next value of every macro-facing pin.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    mask_nxt   = mask;
    x_nxt      = x;
    k_nxt      = k;
    capture_c  = 1'b0;
    drive      = 1'b0;
    eval       = 1'b0;
    ready_nxt  = 1'b0;
    dis_ph_nxt = 1'b0;
    clk_nxt    = '0;
    dis_nxt    = '0;
    x_top_nxt  = '0;
    x_bar_nxt  = '0;
    k_top_nxt  = '0;
    k_bar_nxt  = '0;

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = DISCHARGE;
          cnt_nxt   = CNT_W'(DIS_CYCLES - 1);
          mask_nxt  = lane_en;
          x_nxt     = x_in;
          k_nxt     = k_in;
        end
      end
      DISCHARGE, LOAD, EVAL, HOLD, RECOVER, WAIT: begin
        capture_c = (state == HOLD) && (cnt == '0);
        if (cnt == '0) begin
          state_nxt = next_phase(state);
          cnt_nxt   = (state == WAIT) ? '0 : CNT_W'(PHASE_CYCLES - 1);
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    drive      = (state_nxt == LOAD) || (state_nxt == EVAL) || (state_nxt == HOLD);
    eval       = (state_nxt == EVAL) || (state_nxt == HOLD);
    ready_nxt  = (state_nxt == IDLE);
    dis_ph_nxt = (state_nxt == DISCHARGE);
    clk_nxt    = eval ? mask_nxt : '0;
    dis_nxt    = dis_ph_nxt ? mask_nxt : '0;
    x_top_nxt  = drive ? (x_nxt & mask_nxt) : '0;
    x_bar_nxt  = drive ? (~x_nxt & mask_nxt) : '0;
    k_top_nxt  = drive ? (k_nxt & mask_nxt) : '0;
    k_bar_nxt  = drive ? (~k_nxt & mask_nxt) : '0;
  end

  // Phase state, operands and registered macro pins.
  always_ff @(posedge wb_clk_i) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      mask          <= '0;
      x             <= '0;
      k             <= '0;
      ready         <= 1'b1;
      busy          <= 1'b0;
      Dis_Phase_top <= 1'b0;
      clk_top       <= '0;
      Dis_top       <= '0;
      x_top         <= '0;
      x_bar_top     <= '0;
      k_top         <= '0;
      k_bar_top     <= '0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      mask          <= mask_nxt;
      x             <= x_nxt;
      k             <= k_nxt;
      ready         <= ready_nxt;
      busy          <= ~ready_nxt;
      Dis_Phase_top <= dis_ph_nxt;
      clk_top       <= clk_nxt;
      Dis_top       <= dis_nxt;
      x_top         <= x_top_nxt;
      x_bar_top     <= x_bar_nxt;
      k_top         <= k_top_nxt;
      k_bar_top     <= k_bar_nxt;
    end
  end

  eespfal_rail_checker #(
    .BIT_SIZE(BIT_SIZE)
  ) u_rail_checker (
    .clk       (wb_clk_i),
    .rst_n     (rst_n),
    .capture   (capture_c),
    .mask      (mask),
    .s_top     (s_top),
    .s_bar_top (s_bar_top),
    .s_out     (s_out),
    .s_valid   (s_valid),
    .s_err     (s_err),
    .err_cnt   (err_cnt)
  );

endmodule

// File: tb/tb_eespfal_phase_driver.sv
// Scoreboard bench for eespfal_phase_driver with a behavioural macro model.
// Cycle c of an operation is the value seen between edge c-1 and edge c,
// where edge 0 is the accept edge.
module tb_eespfal_phase_driver;

  logic       wb_clk_i = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] lane_en = '0, x_in = '0, k_in = '0;
  logic       ready, busy, Dis_Phase_top, s_valid, s_err;
  logic [3:0] clk_top, Dis_top, x_top, x_bar_top, k_top, k_bar_top;
  logic [3:0] s_top, s_bar_top, s_out;
  logic [7:0] err_cnt;
  logic       fault = 1'b0;

  typedef struct packed {
    logic [3:0] s;
    logic       e;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_err = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  eespfal_phase_driver dut (
    .wb_clk_i      (wb_clk_i),
    .rst_n         (rst_n),
    .start         (start),
    .lane_en       (lane_en),
    .x_in          (x_in),
    .k_in          (k_in),
    .ready         (ready),
    .busy          (busy),
    .clk_top       (clk_top),
    .Dis_top       (Dis_top),
    .Dis_Phase_top (Dis_Phase_top),
    .x_top         (x_top),
    .x_bar_top     (x_bar_top),
    .k_top         (k_top),
    .k_bar_top     (k_bar_top),
    .s_top         (s_top),
    .s_bar_top     (s_bar_top),
    .s_out         (s_out),
    .s_valid       (s_valid),
    .s_err         (s_err),
    .err_cnt       (err_cnt)
  );

  // Macro model: s = x ^ k on complementary rails; fault shorts lane 1 high.
  always_comb begin
    s_top     = x_top ^ k_top;
    s_bar_top = ~(x_top ^ k_top);
    if (fault) begin
      s_top[1]     = 1'b1;
      s_bar_top[1] = 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [27:0] exp_vec(input int c, input logic [3:0] m,
                                          input logic [3:0] xv, input logic [3:0] kv);
    logic dis, drv, ck, rdy, sv;
    dis = (c >= 1) && (c <= 2);
    drv = (c >= 3) && (c <= 14);
    ck  = (c >= 7) && (c <= 14);
    rdy = (c == 23);
    sv  = (c == 15);
    return {rdy, ~rdy, sv, dis,
            ck ? m : 4'h0, dis ? m : 4'h0,
            drv ? (xv & m) : 4'h0, drv ? (~xv & m) : 4'h0,
            drv ? (kv & m) : 4'h0, drv ? (~kv & m) : 4'h0};
  endfunction

  function automatic logic [27:0] act_vec();
    return {ready, busy, s_valid, Dis_Phase_top, clk_top, Dis_top,
            x_top, x_bar_top, k_top, k_bar_top};
  endfunction

  task automatic push_exp(input logic [3:0] m, input logic [3:0] xv,
                          input logic [3:0] kv, input logic flt);
    exp_t e;
    e.s = (xv ^ kv) & m;
    if (flt) e.s[1] = m[1];
    e.e = flt & m[1];
    if (e.e && exp_err < 255) exp_err++;
    e.cnt = 8'(exp_err);
    sb.push_back(e);
  endtask

  // Pops one expectation per s_valid strobe.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge wb_clk_i);
      if (s_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_s_valid", 32'(s_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          check("s_out", 32'(s_out), 32'(e.s));
          check("s_err", 32'(s_err), 32'(e.e));
          check("err_cnt", 32'(err_cnt), 32'(e.cnt));
        end
      end
    end
  endtask

  // Issues one operation from a negedge while ready; returns at cycle 23.
  task automatic run_op(input logic [3:0] m, input logic [3:0] xv, input logic [3:0] kv,
                        input logic flt, input logic chk_wave, input logic pulse);
    lane_en = m; x_in = xv; k_in = kv; fault = flt; start = 1'b1;
    push_exp(m, xv, kv, flt);
    @(posedge wb_clk_i);
    #1 start = 1'b0;
    for (int c = 1; c <= 23; c++) begin
      @(negedge wb_clk_i);
      if (pulse && c == 10) begin
        start = 1'b1; lane_en = 4'h3; x_in = 4'h5; k_in = 4'h9;
      end
      if (pulse && c == 11) start = 1'b0;
      if (chk_wave) check($sformatf("wave_c%0d", c), 32'(act_vec()), 32'(exp_vec(c, m, xv, kv)));
    end
  endtask

  initial begin
    int acc;
    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(negedge wb_clk_i);
    check("reset_pins", 32'(act_vec()), 32'(exp_vec(23, 4'h0, 4'h0, 4'h0)));
    check("reset_result", 32'({s_out, s_err, err_cnt}), 32'd0);
    rst_n = 1'b1;
    @(negedge wb_clk_i);

    // Basic op, full-mask then partial-mask waveforms
    run_op(4'hF, 4'hA, 4'h6, 1'b0, 1'b1, 1'b0);
    run_op(4'h5, 4'hF, 4'h3, 1'b0, 1'b1, 1'b0);
    run_op(4'h0, 4'hF, 4'hF, 1'b0, 1'b1, 1'b0);

    // Rail fault then saturation of the counter
    run_op(4'hF, 4'hA, 4'h6, 1'b1, 1'b1, 1'b0);
    run_op(4'h5, 4'hA, 4'h6, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 256; i++) run_op(4'h2, 4'(i), 4'h6, 1'b1, 1'b0, 1'b0);
    @(negedge wb_clk_i);
    check("err_cnt_saturated", 32'(err_cnt), 32'd255);
    fault = 1'b0;

    // Start pulse while busy is ignored
    run_op(4'hC, 4'h9, 4'h4, 1'b0, 1'b1, 1'b1);
    repeat (5) begin
      @(negedge wb_clk_i);
      check("idle_after_pulse", 32'({ready, busy}), 32'b10);
    end

    // Start held high for 40 cycles: accepts at edges 0 and 23
    acc = 0;
    lane_en = 4'hF; x_in = 4'h3; k_in = 4'h5; start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (ready && start) begin
        acc++;
        push_exp(4'hF, 4'h3, 4'h5, 1'b0);
        if (i != 0 && i != 23) check("accept_cycle", 32'(i), 32'd0);
      end
      @(negedge wb_clk_i);
    end
    start = 1'b0;
    check("accept_count", 32'(acc), 32'd2);
    repeat (8) @(negedge wb_clk_i);
    check("idle_after_held_start", 32'({ready, busy}), 32'b10);

    // Reset in cycle 9 aborts with null outputs and clears the counter
    lane_en = 4'hF; x_in = 4'hA; k_in = 4'h6; start = 1'b1;
    @(posedge wb_clk_i);
    #1 start = 1'b0;
    for (int c = 1; c <= 9; c++) @(negedge wb_clk_i);
    rst_n = 1'b0;
    @(negedge wb_clk_i);
    exp_err = 0;
    check("midop_reset_pins", 32'(act_vec()), 32'(exp_vec(23, 4'h0, 4'h0, 4'h0)));
    check("midop_reset_result", 32'({s_out, s_err, err_cnt}), 32'd0);
    rst_n = 1'b1;
    repeat (30) @(negedge wb_clk_i);
    check("idle_after_reset", 32'({ready, busy, err_cnt}), 32'({2'b10, 8'd0}));

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
